series_engine_scheduler: RTL and testbench

Round-robin scheduler that shares one series-computation engine (the LUT/multiply/accumulate datapath sequenced by its own start/ready controller) between `N_REQ` requesters. It grants one requester at a time, presents that requester's operand to the engine, and issues the engine start pulse. It then waits for the engine to finish, returns the registered result with a one-cycle `done` pulse, and aborts the run through the engine's `stop` input if the run exceeds a watchdog limit.

---
 rtl/series_engine_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_series_engine_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/series_engine_scheduler.sv
// Round-robin scheduler sharing one series-computation engine among N_REQ requesters.
// Grants one requester, starts the engine, collects the result and aborts overlong runs.
module series_engine_scheduler #(
    parameter int N_REQ   = 4,
    parameter int XW      = 8,
    parameter int RW      = 16,
    parameter int MAX_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*XW-1:0]   req_x,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic                  err,
    output logic [RW-1:0]         result,
    output logic                  busy,
    output logic                  eng_start,
    output logic                  eng_stop,
    output logic [XW-1:0]         eng_x,
    input  logic                  eng_ready,
    input  logic [RW-1:0]         eng_result
);

    localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WDW = $clog2(MAX_CYC + 1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(MAX_CYC);
    localparam logic [WDW-1:0] WD_LAST = WDW'(MAX_CYC - 1);
    localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        ABORT     = 3'd5,
        DELIVER   = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                err_q, err_d;
    logic [RW-1:0]       result_q, result_d;
    logic                busy_q, busy_d;
    logic                eng_start_q, eng_start_d;
    logic                eng_stop_q, eng_stop_d;
    logic [XW-1:0]       eng_x_q, eng_x_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [WDW-1:0]      wd_q, wd_d;

    logic [IW-1:0]       sel_idx_s;
    logic                sel_vld_s;
    logic [IW-1:0]       cand_s;
    logic [WDW-1:0]      wd_inc_s;
    logic                timeout_s;

    // (base + off) mod N_REQ for off in 0..N_REQ-1
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end else begin
            s = s;
        end
        return s[IW-1:0];
    endfunction

    // Round-robin pick: scan downward so the candidate closest to ptr wins last
    always_comb begin
        sel_vld_s = 1'b0;
        sel_idx_s = '0;
        cand_s    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_s = wrap_idx(ptr_q, k);
            if (req[cand_s]) begin
                sel_vld_s = 1'b1;
                sel_idx_s = cand_s;
            end else begin
                sel_vld_s = sel_vld_s;
                sel_idx_s = sel_idx_s;
            end
        end
    end

    // Saturating watchdog increment and the "about to reach MAX_CYC" timeout
    always_comb begin
        wd_inc_s  = (wd_q == WD_MAX) ? wd_q : (wd_q + WD_ONE);
        timeout_s = (wd_q >= WD_LAST);
    end

    // Next-state and next-output computation for the scheduler FSM
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = 1'b0;
        result_d    = result_q;
        busy_d      = busy_q;
        eng_start_d = 1'b0;
        eng_stop_d  = eng_stop_q;
        eng_x_d     = eng_x_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        wd_d        = wd_q;

        case (state_q)
            IDLE: begin
                if (sel_vld_s) begin
                    state_d          = GRANT;
                    gnt_d            = '0;
                    gnt_d[sel_idx_s] = 1'b1;
                    idx_d            = sel_idx_s;
                    eng_x_d          = req_x[int'(sel_idx_s) * XW +: XW];
                    busy_d           = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                state_d     = START;
                eng_start_d = 1'b1;
                wd_d        = '0;
            end
            START: begin
                state_d = WAIT_BUSY;
                wd_d    = wd_inc_s;
            end
            WAIT_BUSY: begin
                wd_d = wd_inc_s;
                // Timeout outranks the engine picking up the start
                if (timeout_s) begin
                    state_d    = ABORT;
                    eng_stop_d = 1'b1;
                end else if (!eng_ready) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                wd_d = wd_inc_s;
                // A normal completion outranks a simultaneous timeout
                if (eng_ready) begin
                    state_d  = DELIVER;
                    result_d = eng_result;
                    done_d   = gnt_q;
                    err_d    = 1'b0;
                end else if (timeout_s) begin
                    state_d    = ABORT;
                    eng_stop_d = 1'b1;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            ABORT: begin
                if (eng_ready) begin
                    state_d    = DELIVER;
                    result_d   = eng_result;
                    eng_stop_d = 1'b0;
                    done_d     = gnt_q;
                    err_d      = 1'b1;
                end else begin
                    state_d = ABORT;
                end
            end
            DELIVER: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                ptr_d   = wrap_idx(idx_q, 1);
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                busy_d     = 1'b0;
                eng_stop_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
            eng_stop_q  <= 1'b0;
            eng_x_q     <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            eng_start_q <= eng_start_d;
            eng_stop_q  <= eng_stop_d;
            eng_x_q     <= eng_x_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign eng_start = eng_start_q;
    assign eng_stop  = eng_stop_q;
    assign eng_x     = eng_x_q;

endmodule

// File: tb/tb_series_engine_scheduler.sv
// Randomized bench for series_engine_scheduler: a transaction-level model predicts
// winner, latency, abort and result of each service; a small engine model drives eng_*.
module tb_series_engine_scheduler;

    localparam int N    = 4;
    localparam int XW   = 8;
    localparam int RW   = 16;
    localparam int MAXC = 20;

    localparam int M_NORMAL = 0;
    localparam int M_HANG   = 1;
    localparam int M_NODROP = 2;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*XW-1:0]   req_x;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic              err;
    logic [RW-1:0]     result;
    logic              busy;
    logic              eng_start;
    logic              eng_stop;
    logic [XW-1:0]     eng_x;
    logic              eng_ready;
    logic [RW-1:0]     eng_result;

    int                checks;
    int                failures;
    int                model_ptr;
    int                cfg_mode;
    int                cfg_len;
    logic [RW-1:0]     cfg_res;

    series_engine_scheduler #(
        .N_REQ  (N),
        .XW     (XW),
        .RW     (RW),
        .MAX_CYC(MAXC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_x     (req_x),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .result    (result),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_stop  (eng_stop),
        .eng_x     (eng_x),
        .eng_ready (eng_ready),
        .eng_result(eng_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=stuck required=finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ctl_vec();
        return {20'd0, gnt, done, err, busy, eng_start, eng_stop};
    endfunction

    // Engine: reacts to start one cycle later; ready low for cfg_len cycles (NORMAL),
    // until stop was seen 3 cycles (HANG), or never drops (NODROP)
    initial begin : engine_model
        bit s;
        bit p;
        bit running;
        int left;
        int stops;
        eng_ready  = 1'b1;
        eng_result = '0;
        running    = 1'b0;
        left       = 0;
        stops      = 0;
        forever begin
            @(negedge clk);
            s = eng_start;
            p = eng_stop;
            @(posedge clk);
            #1;
            if (!rst) begin
                running   = 1'b0;
                eng_ready = 1'b1;
            end else if (s) begin
                running   = (cfg_mode != M_NODROP);
                eng_ready = (cfg_mode == M_NODROP);
                left      = cfg_len;
                stops     = 0;
            end else if (running) begin
                if (p) stops++;
                left--;
                if ((cfg_mode == M_NORMAL && left == 0) || (cfg_mode == M_HANG && stops == 3)) begin
                    running    = 1'b0;
                    eng_ready  = 1'b1;
                    eng_result = cfg_res;
                end
            end
        end
    end

    // Idle cycles with no request: every control output stays low
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val("idle_ctl", ctl_vec(), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // One service, entered at posedge+1 of the cycle in which the DUT sits in IDLE
    task automatic serve(input logic [N-1:0] r, input logic [N*XW-1:0] x, input int mode,
                         input int len, input logic [RW-1:0] res, input bit drop);
        int w;
        int rr;
        int dl;
        bit ab;
        logic [N-1:0]  oh;
        logic [RW-1:0] exp_res;
        logic [31:0]   exp_ctl;
        req   = r;
        req_x = x;
        w = -1;
        for (int off = 0; off < N; off++) begin
            if (w < 0 && r[(model_ptr + off) % N]) w = (model_ptr + off) % N;
        end
        if (w < 0) begin
            idle_cycles(1);
            return;
        end
        cfg_mode = mode;
        cfg_len  = len;
        cfg_res  = res;
        oh = '0;
        oh[w] = 1'b1;
        if (mode == M_NORMAL)    rr = 3 + len;
        else if (mode == M_HANG) rr = MAXC + 5;
        else                     rr = MAXC + 2;
        ab      = (rr > MAXC + 1);
        dl      = rr + 1;
        exp_res = (mode == M_NODROP) ? eng_result : res;
        for (int c = 0; c <= dl; c++) begin
            @(negedge clk);
            exp_ctl = {20'd0,
                       (c >= 1) ? oh : 4'b0000,
                       (c == dl) ? oh : 4'b0000,
                       (c == dl) && ab,
                       (c >= 1),
                       (c == 2),
                       ab && (c >= MAXC + 2) && (c <= rr)};
            check_val($sformatf("ctl_req%0d_c%0d", w, c), ctl_vec(), exp_ctl);
            if (c == 1 || c == dl) check_val("eng_x", {24'd0, eng_x}, {24'd0, x[w*XW +: XW]});
            if (c == dl) check_val("result", {16'd0, result}, {16'd0, exp_res});
            @(posedge clk);
            #1;
            if (c == 1) begin
                req_x = $urandom;
                if (drop) req = '0;
            end
        end
        model_ptr = (w + 1) % N;
    endtask

    initial begin
        int mode;
        int len;
        checks    = 0;
        failures  = 0;
        model_ptr = 0;
        cfg_mode  = M_NORMAL;
        cfg_len   = 1;
        cfg_res   = '0;
        rst   = 1'b0;
        req   = '0;
        req_x = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_ctl", ctl_vec(), 32'd0);
        check_val("reset_result", {16'd0, result}, 32'd0);
        check_val("reset_eng_x", {24'd0, eng_x}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single request with the documented 10-cycle latency
        serve(4'b0001, 32'h0000_0005, M_NORMAL, 6, 16'h1234, 1'b0);
        model_ptr = 0;
        // Bring the real pointer back to 0 by serving requester 3
        serve(4'b1000, 32'h4400_0000, M_NORMAL, 1, 16'h0001, 1'b0);

        // Simultaneous requests, then ptr=3 shows through, then wrap order 0,1,2,3,0
        serve(4'b0110, 32'h0033_2200, M_NORMAL, 2, 16'h00aa, 1'b0);
        serve(4'b0110, 32'h0033_2200, M_NORMAL, 3, 16'h00bb, 1'b0);
        for (int i = 0; i < 6; i++) serve(4'b1111, 32'hd4c3_b2a1, M_NORMAL, 1 + i, 16'h0100 + 16'(i), 1'b0);

        // Watchdog boundaries
        serve(4'b0001, 32'h0000_0011, M_HANG,   0,  16'hbeef, 1'b0);
        serve(4'b0010, 32'h0000_2200, M_NODROP, 0,  16'h0bad, 1'b0);
        serve(4'b0100, 32'h0033_0000, M_NORMAL, 18, 16'h1818, 1'b0);
        serve(4'b1000, 32'h4400_0000, M_NORMAL, 19, 16'h1919, 1'b0);

        // Withdrawal right after the grant: service completes, no re-grant
        serve(4'b0010, 32'h0000_7700, M_NORMAL, 4, 16'h7777, 1'b1);
        idle_cycles(3);

        // Reset while waiting for the engine to finish
        serve(4'b0100, 32'h0099_0000, M_NORMAL, 2, 16'h5a5a, 1'b0);
        req      = 4'b1 << model_ptr;
        req_x    = 32'h5555_5555;
        cfg_mode = M_NORMAL;
        cfg_len  = 12;
        cfg_res  = 16'hcafe;
        repeat (6) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_val("midreset_ctl", ctl_vec(), 32'd0);
        check_val("midreset_result", {16'd0, result}, 32'd0);
        check_val("midreset_eng_x", {24'd0, eng_x}, 32'd0);
        req = '0;
        model_ptr = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        serve(4'b1010, 32'h6600_4400, M_NORMAL, 3, 16'h0f0f, 1'b0);
        serve(4'b1000, 32'h6600_4400, M_NORMAL, 3, 16'hf0f0, 1'b0);

        // Randomized services
        for (int i = 0; i < 60; i++) begin
            len  = $urandom_range(1, 20);
            mode = M_NORMAL;
            if ($urandom_range(0, 9) == 0) mode = M_HANG;
            else if ($urandom_range(0, 9) == 0) mode = M_NODROP;
            serve(4'($urandom_range(0, 15)), $urandom, mode, len, 16'($urandom),
                  ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
